pc_sequencer: RTL and testbench

Program-counter and run-control stage that sits directly upstream of the single-cycle I-format datapath. It holds the PC and drives it onto the datapath's instruction-address input. It captures the datapath's PC+4 result as the next PC and gates instruction commit through a run/step/halt state machine. It also counts retired instructions for the bench and debug.

---
 rtl/pc_sequencer.sv | 81 ++++++++
 tb/tb_pc_sequencer.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/pc_sequencer.sv
// Program counter and run/step/halt control for the single-cycle datapath.
// Optional PC_LIMIT_EN macro: halt once the next PC reaches PC_LIMIT.
module pc_sequencer #(
    parameter logic [31:0] RESET_ADDR = 32'h0000_0000,
    parameter logic [31:0] PC_LIMIT   = 32'h0000_0100
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        step,
    input  logic        halt_req,
    input  logic [31:0] Next_Addr,
    output logic [31:0] Fetch_Addr,
    output logic        exec_en,
    output logic        running,
    output logic        halted,
    output logic [31:0] Retired_Count
);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        STEP,
        HALT
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q;
    logic [31:0] cnt_q;
    logic        limit_hit;

`ifdef PC_LIMIT_EN
    assign limit_hit = (Next_Addr >= PC_LIMIT);
`else
    logic unused_limit;
    assign unused_limit = ^PC_LIMIT;
    assign limit_hit    = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            pc_q    <= RESET_ADDR;
            cnt_q   <= 32'd0;
        end else begin
            state_q <= state_d;
            if (exec_en) begin
                pc_q  <= Next_Addr;
                cnt_q <= cnt_q + 32'd1;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (halt_req)   state_d = HALT;
                else if (start) state_d = RUN;
                else if (step)  state_d = STEP;
            end
            RUN: begin
                if (halt_req || limit_hit) state_d = HALT;
            end
            STEP: begin
                if (halt_req || limit_hit) state_d = HALT;
                else                       state_d = IDLE;
            end
            HALT: state_d = HALT;
            default: state_d = IDLE;
        endcase
    end

    // Moore decode: exec_en falls with the state, so reset kills a commit at once.
    assign exec_en       = (state_q == RUN) || (state_q == STEP);
    assign running       = (state_q == RUN);
    assign halted        = (state_q == HALT);
    assign Fetch_Addr    = pc_q;
    assign Retired_Count = cnt_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer; datapath modelled as Next_Addr = PC + 4.
// Build with +define+PC_LIMIT_EN to exercise the limit halt at RA+0x10.
module tb_pc_sequencer;

    localparam logic [31:0] RA  = 32'h0000_0040;
    localparam logic [31:0] LIM = 32'h0000_0050;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic        step = 1'b0;
    logic        halt_req = 1'b0;
    logic [31:0] Next_Addr;
    logic [31:0] Fetch_Addr;
    logic        exec_en;
    logic        running;
    logic        halted;
    logic [31:0] Retired_Count;

    logic        ovr_en = 1'b0;
    logic [31:0] ovr_val = 32'h0;
    logic        reg_write = 1'b1;
    logic        wr_gated;

    int checks = 0;
    int errors = 0;

    assign Next_Addr = ovr_en ? ovr_val : Fetch_Addr + 32'd4;
    assign wr_gated  = reg_write & exec_en;

    always #5 clk = ~clk;

    pc_sequencer #(
        .RESET_ADDR(RA),
        .PC_LIMIT  (LIM)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .step         (step),
        .halt_req     (halt_req),
        .Next_Addr    (Next_Addr),
        .Fetch_Addr   (Fetch_Addr),
        .exec_en      (exec_en),
        .running      (running),
        .halted       (halted),
        .Retired_Count(Retired_Count)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        #1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        // Reset asserted between edges
        #12;
        rst = 1'b1;
        #1;
        chk("rst_pc", Fetch_Addr, RA);
        chk("rst_exec", {31'd0, exec_en}, 32'd0);
        chk("rst_cnt", Retired_Count, 32'd0);
        chk("rst_run", {31'd0, running}, 32'd0);
        chk("rst_halt", {31'd0, halted}, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Single step
        step = 1'b1;
        tick();
        step = 1'b0;
        chk("step_exec", {31'd0, exec_en}, 32'd1);
        chk("step_run", {31'd0, running}, 32'd0);
        chk("step_pc0", Fetch_Addr, RA);
        tick();
        chk("step_pc1", Fetch_Addr, RA + 32'h4);
        chk("step_cnt", Retired_Count, 32'd1);
        chk("step_idle", {31'd0, exec_en}, 32'd0);
        tick();
        chk("step_hold", Fetch_Addr, RA + 32'h4);
        chk("step_cnt2", Retired_Count, 32'd1);

        // Held step: one commit every two cycles
        step = 1'b1;
        tick();
        chk("hstep_e1", {31'd0, exec_en}, 32'd1);
        tick();
        chk("hstep_e2", {31'd0, exec_en}, 32'd0);
        tick();
        tick();
        step = 1'b0;
        chk("hstep_pc", Fetch_Addr, RA + 32'hC);
        chk("hstep_cnt", Retired_Count, 32'd3);
        chk("hstep_exec", {31'd0, exec_en}, 32'd0);

        // Start + step together: start wins, then run
        do_reset();
        start = 1'b1;
        step  = 1'b1;
        tick();
        start = 1'b0;
        step  = 1'b0;
        chk("ss_run", {31'd0, running}, 32'd1);
        chk("run_pc0", Fetch_Addr, RA);
        tick();
        chk("run_pc1", Fetch_Addr, RA + 32'h4);
        tick();
        chk("run_pc2", Fetch_Addr, RA + 32'h8);

        // Async reset mid-run at PC RA+8
        #2;
        rst = 1'b1;
        #1;
        chk("mrst_exec", {31'd0, exec_en}, 32'd0);
        chk("mrst_wr", {31'd0, wr_gated}, 32'd0);
        chk("mrst_pc", Fetch_Addr, RA);
        chk("mrst_cnt", Retired_Count, 32'd0);
        chk("mrst_run", {31'd0, running}, 32'd0);
        tick();
        chk("mrst_pc2", Fetch_Addr, RA);
        @(negedge clk);
        rst = 1'b0;

        // Halt while running at RA+8
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        chk("h_pre_pc", Fetch_Addr, RA + 32'h8);
        halt_req = 1'b1;
        tick();
        halt_req = 1'b0;
        chk("h_pc", Fetch_Addr, RA + 32'hC);
        chk("h_cnt", Retired_Count, 32'd3);
        chk("h_halted", {31'd0, halted}, 32'd1);
        chk("h_exec", {31'd0, exec_en}, 32'd0);
        start = 1'b1;
        step  = 1'b1;
        tick();
        tick();
        start = 1'b0;
        step  = 1'b0;
        chk("h_sticky_pc", Fetch_Addr, RA + 32'hC);
        chk("h_sticky_cnt", Retired_Count, 32'd3);
        chk("h_sticky_st", {31'd0, halted}, 32'd1);

        // Next_Addr used verbatim, no alignment
        do_reset();
        chk("rst2_halt", {31'd0, halted}, 32'd0);
        ovr_en  = 1'b1;
        ovr_val = 32'h1234_5679;
        step = 1'b1;
        tick();
        step = 1'b0;
        tick();
        chk("verb_pc", Fetch_Addr, 32'h1234_5679);
        chk("verb_cnt", Retired_Count, 32'd1);
`ifdef PC_LIMIT_EN
        chk("verb_lim", {31'd0, halted}, 32'd1);
`else
        chk("verb_lim", {31'd0, halted}, 32'd0);
`endif
        ovr_en = 1'b0;

        // Limit at RA+0x10
        do_reset();
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        tick();
        tick();
        chk("lim_pc", Fetch_Addr, RA + 32'h10);
        chk("lim_cnt", Retired_Count, 32'd4);
`ifdef PC_LIMIT_EN
        chk("lim_halted", {31'd0, halted}, 32'd1);
        tick();
        chk("lim_pc_hold", Fetch_Addr, RA + 32'h10);
`else
        chk("lim_running", {31'd0, running}, 32'd1);
        tick();
        chk("lim_pc_past", Fetch_Addr, RA + 32'h14);
        chk("lim_cnt_past", Retired_Count, 32'd5);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
